// File: rtl/sdf_twiddle_mult.sv
// Twiddle-multiply stage of a radix-2 SDF FFT: tracks frame position, addresses the
// twiddle ROM and multiplies second-half butterfly outputs by the returned twiddle.
module sdf_twiddle_mult #(
  parameter int NFFT       = 128,
  parameter int DATA_WIDTH = 16,
  parameter int STAGE      = 0,
  parameter int TW_FRAC    = 14
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic                          in_sof,
  input  logic [DATA_WIDTH-1:0]         in_real,
  input  logic [DATA_WIDTH-1:0]         in_imag,
  output logic [$clog2(NFFT/2)-1:0]     tw_addr,
  input  logic [DATA_WIDTH-1:0]         tw_real,
  input  logic [DATA_WIDTH-1:0]         tw_imag,
  output logic                          out_valid,
  output logic                          out_sof,
  output logic [DATA_WIDTH-1:0]         out_real,
  output logic [DATA_WIDTH-1:0]         out_imag
);

  localparam int CNT_W  = $clog2(NFFT);
  localparam int ADDR_W = $clog2(NFFT / 2);
  localparam int M      = NFFT >> STAGE;
  localparam int PW     = 2 * DATA_WIDTH;
  localparam int SW     = 2 * DATA_WIDTH + 1;

  localparam logic [CNT_W-1:0]     K_MASK  = CNT_W'(M - 1);
  localparam logic [CNT_W-1:0]     HALF    = CNT_W'(M / 2);
  localparam logic signed [SW-1:0] RND     = SW'(1) <<< (TW_FRAC - 1);
  localparam logic signed [SW-1:0] SAT_MAX = SW'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  // Round half up by TW_FRAC bits, then clamp to the output range.
  function automatic logic signed [DATA_WIDTH-1:0] round_sat(input logic signed [SW-1:0] x);
    logic signed [SW-1:0] r;
    r = (x + RND) >>> TW_FRAC;
    if (r > SAT_MAX) begin
      return SAT_MAX[DATA_WIDTH-1:0];
    end else if (r < SAT_MIN) begin
      return SAT_MIN[DATA_WIDTH-1:0];
    end
    return r[DATA_WIDTH-1:0];
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pos;
  logic [CNT_W-1:0] k;
  logic             bypass;

  always_comb begin
    pos     = (in_valid && in_sof) ? '0 : cnt_q;
    k       = pos & K_MASK;
    bypass  = (k < HALF);
    tw_addr = bypass ? '0 : ADDR_W'((k - HALF) << STAGE);
    cnt_d   = in_valid ? pos + 1'b1 : cnt_q;
  end

  logic                         vld_p1_q, sof_p1_q, byp_p1_q;
  logic signed [DATA_WIDTH-1:0] re_p1_q, im_p1_q, twr_p1_q, twi_p1_q;

  logic                         vld_p2_q, sof_p2_q, byp_p2_q;
  logic signed [DATA_WIDTH-1:0] re_p2_q, im_p2_q;
  logic signed [PW-1:0]         ac_p2_q, bd_p2_q, ad_p2_q, bc_p2_q;

  logic                         out_valid_q, out_sof_q;
  logic signed [DATA_WIDTH-1:0] out_real_q, out_imag_q;

  logic signed [SW-1:0] re_sum, im_sum;

  assign re_sum = SW'(ac_p2_q) - SW'(bd_p2_q);
  assign im_sum = SW'(ad_p2_q) + SW'(bc_p2_q);

  // P1: capture sample, twiddle and flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      vld_p1_q <= 1'b0;
      sof_p1_q <= 1'b0;
      byp_p1_q <= 1'b0;
      re_p1_q  <= '0;
      im_p1_q  <= '0;
      twr_p1_q <= '0;
      twi_p1_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      vld_p1_q <= in_valid;
      sof_p1_q <= in_valid & in_sof;
      byp_p1_q <= bypass;
      re_p1_q  <= signed'(in_real);
      im_p1_q  <= signed'(in_imag);
      twr_p1_q <= signed'(tw_real);
      twi_p1_q <= signed'(tw_imag);
    end
  end

  // P2: partial products; bypass data rides alongside
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2_q <= 1'b0;
      sof_p2_q <= 1'b0;
      byp_p2_q <= 1'b0;
      re_p2_q  <= '0;
      im_p2_q  <= '0;
      ac_p2_q  <= '0;
      bd_p2_q  <= '0;
      ad_p2_q  <= '0;
      bc_p2_q  <= '0;
    end else begin
      vld_p2_q <= vld_p1_q;
      sof_p2_q <= sof_p1_q;
      byp_p2_q <= byp_p1_q;
      re_p2_q  <= re_p1_q;
      im_p2_q  <= im_p1_q;
      ac_p2_q  <= PW'(re_p1_q) * PW'(twr_p1_q);
      bd_p2_q  <= PW'(im_p1_q) * PW'(twi_p1_q);
      ad_p2_q  <= PW'(re_p1_q) * PW'(twi_p1_q);
      bc_p2_q  <= PW'(im_p1_q) * PW'(twr_p1_q);
    end
  end

  // P3: combine, round, saturate; data holds across bubbles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
    end else begin
      out_valid_q <= vld_p2_q;
      out_sof_q   <= sof_p2_q;
      if (vld_p2_q) begin
        out_real_q <= byp_p2_q ? re_p2_q : round_sat(re_sum);
        out_imag_q <= byp_p2_q ? im_p2_q : round_sat(im_sum);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_real  = out_real_q;
  assign out_imag  = out_imag_q;

endmodule

// File: doc/sdf_twiddle_mult.md
Name: sdf_twiddle_mult

Overview:
- Twiddle-multiply stage of the 128-point radix-2 SDF FFT.
- Sits between one stage's butterfly output and the next stage's delay-feedback input.
- Tracks sample position within each frame and drives the address of the combinational twiddle ROM.
- Multiplies second-half samples of each butterfly block by the returned complex twiddle, then rounds and saturates.
- First-half samples bypass the multiplier with matched latency; no back-pressure.

Parameters:
NFFT, 128, FFT points (power of 2, ≥4)
DATA_WIDTH, 16, signed width of sample and twiddle components
STAGE, 0, SDF stage index 0..log2(NFFT)-2; block size M = NFFT>>STAGE
TW_FRAC, 14, fractional bits of twiddle words (Q2.14 default, so +1.0 = 16384)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input sample valid
in_sof  in  1  first sample of frame, qualified by in_valid
in_real  in  DATA_WIDTH  signed input real
in_imag  in  DATA_WIDTH  signed input imag
tw_addr  out  log2(NFFT/2)  address to twiddle ROM (combinational)
tw_real  in  DATA_WIDTH  ROM real data for tw_addr, same cycle
tw_imag  in  DATA_WIDTH  ROM imag data for tw_addr, same cycle
out_valid  out  1  output valid
out_sof  out  1  delayed in_sof
out_real  out  DATA_WIDTH  signed result real
out_imag  out  DATA_WIDTH  signed result imag

Behaviour:
- Reset (rst_n low at a clk edge):
  - Sample counter cnt (log2(NFFT) bits) cleared to 0.
  - All pipeline registers cleared; out_valid=0, out_sof=0, out_real=0, out_imag=0.
  - Reset mid-frame discards in-flight samples and restarts at position 0.
- Position:
  - pos = 0 if (in_valid & in_sof), else cnt.
  - On in_valid, cnt <= pos+1, wrapping NFFT-1 -> 0.
  - No in_valid: cnt holds. in_sof without in_valid is ignored.
- Address, combinational from pos:
  - k = pos mod M.
  - If k ≥ M/2: tw_addr = (k - M/2) << STAGE.
  - Else: tw_addr = 0 and sample flagged bypass.
- Pipeline: 3 cycles, fixed, from in_valid to out_valid. Valid, sof and bypass flags travel alongside the data.
  - P1 registers in_real/in_imag, tw_real/tw_imag and flags.
  - P2 registers the four 2*DATA_WIDTH signed products: ac, bd, ad, bc.
  - P3:
    - re = ac - bd, im = ad + bc, each 2*DATA_WIDTH+1 bits.
    - Add 2^(TW_FRAC-1) and arithmetic-shift right by TW_FRAC (round half up).
    - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Bypass samples: the P1 input values are carried unmodified to the outputs at the same latency; the multiplier result is ignored.
- Bubbles: in_valid=0 cycles propagate as out_valid=0. When out_valid=0, out_real and out_imag hold their previous values.
- Back-to-back valid samples: full throughput, one sample per cycle.
- Frame length is always NFFT valid samples. An in_sof arriving early resynchronises the counter; its partial frame is still processed.

Test Plan:
- Reset: hold rst_n=0 for 3 clocks while driving in_valid=1 -> out_valid=0, outputs 0; after release, the first output appears exactly 3 cycles after the first in_valid.
- STAGE=0, sof, then a 128-sample ramp with a ROM model -> tw_addr stays 0 for k=0..63 and is 0..63 for k=64..127; samples 0..63 exit unchanged.
- STAGE=0, k=96, input (1000,-500), ROM(32)=(0,-16384) -> output (-500,-1000) at 3-cycle latency. At k=64 with ROM(0)=(16384,0) -> output (1000,-500).
- Saturation: k=80 (addr 16, W=(11585,-11585)), input (-32768,-32768) -> output (-32768,0).
- STAGE=2 (M=32): pos 16..31 -> tw_addr 0,4,...,60; pos 32..47 bypass; pos 48 -> tw_addr 0.
- in_valid toggling 1/0 plus an early in_sof at pos 50 -> the counter holds during gaps and restarts at 0 on the sof; out_sof is aligned with the corresponding out_valid.
